drive_cmd_ctrl: RTL

//  Command layer between uart_rx and the two motor_driver instances. Checks each received byte,

---
 rtl/drive_pkg.sv | 30 +++
 rtl/reversal_interlock.sv | 63 ++++++
 rtl/drive_cmd_ctrl.sv | 89 ++++++++
 3 files changed

// File: rtl/drive_pkg.sv
// Shared types and constants for the drive command layer.
// Drive codes map 1:1 onto the motor_driver speed/dir pins.
package drive_pkg;

  typedef enum logic [1:0] {
    COAST = 2'b00,
    FWD   = 2'b01,
    REV   = 2'b10,
    BRAKE = 2'b11
  } drive_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ESTOP = 2'd2
  } ctrl_state_t;

  localparam logic [1:0] HDR_DRIVE   = 2'b01;
  localparam logic [7:0] BYTE_ESTOP  = 8'hC0;
  localparam logic [7:0] BYTE_RESUME = 8'hA5;

  function automatic logic is_dir(input drive_t d);
    return (d == FWD) || (d == REV);
  endfunction

  function automatic logic is_reversal(input drive_t req, input drive_t last);
    return ((req == FWD) && (last == REV)) || ((req == REV) && (last == FWD));
  endfunction

endpackage

// File: rtl/reversal_interlock.sv
// Per-motor FWD<->REV interlock: forces COAST for DEAD_CYCLES before a
// direction change reaches the motor. DEAD_CYCLES must be at least 1.
module reversal_interlock
  import drive_pkg::*;
#(
  parameter int DEAD_CYCLES = 1000
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  drive_t req,
  input  logic   flush,
  output drive_t out
);

  localparam int CW = $clog2(DEAD_CYCLES + 1);

  logic [CW-1:0] dead_cnt;
  drive_t        pend;
  drive_t        last_dir;
  drive_t        nxt_pend;
  logic          in_dead;

  assign in_dead  = (dead_cnt != '0);
  assign nxt_pend = load ? req : pend;

  // last_dir survives flush: a coasting motor still remembers which way it last spun
  always_ff @(posedge clk) begin
    if (reset) begin
      out      <= COAST;
      pend     <= COAST;
      last_dir <= COAST;
      dead_cnt <= '0;
    end else if (flush) begin
      out      <= COAST;
      pend     <= COAST;
      dead_cnt <= '0;
    end else if (in_dead) begin
      if (load && !is_dir(req)) begin
        out      <= req;
        pend     <= COAST;
        dead_cnt <= '0;
      end else begin
        pend     <= nxt_pend;
        dead_cnt <= dead_cnt - 1'b1;
        if (dead_cnt == CW'(1)) begin
          out      <= nxt_pend;
          last_dir <= nxt_pend;
        end
      end
    end else if (load) begin
      if (is_reversal(req, last_dir)) begin
        out      <= COAST;
        pend     <= req;
        dead_cnt <= CW'(DEAD_CYCLES);
      end else begin
        out <= req;
        if (is_dir(req)) last_dir <= req;
      end
    end
  end

endmodule

// File: rtl/drive_cmd_ctrl.sv
// UART byte checker, e-stop/watchdog state machine and error counter,
// feeding one reversal interlock per motor (lane 1 = left, lane 0 = right).
module drive_cmd_ctrl
  import drive_pkg::*;
#(
  parameter int TIMEOUT     = 2_000_000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [1:0] left_cmd,
  output logic [1:0] right_cmd,
  output logic [1:0] state,
  output logic [7:0] err_cnt
);

  localparam int NUM_LANES = 2;
  localparam int WW        = $clog2(TIMEOUT);

  ctrl_state_t cur_st, nxt_st;
  logic [WW-1:0] wd;
  logic          is_drv, is_est, is_res, acc, wd_hit, wd_exp, flush, rej;
  drive_t [NUM_LANES-1:0] mot_req;
  drive_t [NUM_LANES-1:0] mot_out;

  // drive byte: header 01, bit0 clear, even parity over [7:1]
  assign is_drv = rx_valid && (rx_data[7:6] == HDR_DRIVE) && !rx_data[0] && !(^rx_data[7:1]);
  assign is_est = rx_valid && (rx_data == BYTE_ESTOP);
  assign is_res = rx_valid && (rx_data == BYTE_RESUME);
  assign rej    = rx_valid && !is_drv && !is_est && !is_res;
  assign acc    = is_drv && (cur_st != ESTOP);
  assign wd_hit = (wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) cur_st <= IDLE;
    else       cur_st <= nxt_st;
  end

  always_comb begin
    nxt_st = cur_st;
    case (cur_st)
      IDLE:    if (is_est) nxt_st = ESTOP;
               else if (acc) nxt_st = RUN;
      RUN:     if (is_est) nxt_st = ESTOP;
               else if (wd_exp) nxt_st = IDLE;
      ESTOP:   if (is_res) nxt_st = IDLE;
      default: nxt_st = IDLE;
    endcase
  end

  // an accepted drive byte on the expiry cycle suppresses the timeout
  always_comb begin
    wd_exp = (cur_st == RUN) && wd_hit && !acc;
    flush  = is_est || wd_exp;
    state  = cur_st;
  end

  always_ff @(posedge clk) begin
    if (reset)                         wd <= '0;
    else if (acc)                      wd <= '0;
    else if (cur_st == RUN && !wd_hit) wd <= wd + 1'b1;
    else                               wd <= '0;
  end

  always_ff @(posedge clk) begin
    if (reset)                       err_cnt <= '0;
    else if (rej && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
  end

  assign mot_req[1] = drive_t'(rx_data[5:4]);
  assign mot_req[0] = drive_t'(rx_data[3:2]);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_mot
    reversal_interlock #(.DEAD_CYCLES(DEAD_CYCLES)) u_ilk (
      .clk   (clk),
      .reset (reset),
      .load  (acc),
      .req   (mot_req[i]),
      .flush (flush),
      .out   (mot_out[i])
    );
  end

  assign left_cmd  = mot_out[1];
  assign right_cmd = mot_out[0];

endmodule
